sram_responder: RTL

Clocked responder for the 5-pin SRAM control bus, 18-bit address bus and 16-bit bidirectional data bus driven by the data logger. It stands in for the external 256K×16 asynchronous SRAM, backed by on-chip memory, so the system runs and is verified without the off-chip part. It decodes the chip-enable, output-enable, write-enable and byte-lane pins, commits writes, and returns read data on the shared bus. It also keeps access counters and a conflict flag for debug.

---
 rtl/sram_responder_if.sv | 25 ++
 rtl/sram_responder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sram_responder_if.sv
// Control and address side of the logger's SRAM bus, plus the responder's debug counters.
// The bidirectional data bus stays a plain inout port on the responder.
interface sram_responder_if;
  logic [4:0]  sram_control;
  logic [17:0] Direcciones;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        conflict;

  modport master (
    output sram_control,
    output Direcciones,
    input  rd_count,
    input  wr_count,
    input  conflict
  );

  modport slave (
    input  sram_control,
    input  Direcciones,
    output rd_count,
    output wr_count,
    output conflict
  );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the 256Kx16 asynchronous SRAM: decodes the active-low control pins,
// commits byte-laned writes once per we_n pulse and drives registered read data per lane.
module sram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  sram_responder_if.slave  bus,
  inout  wire  [15:0]      Datos
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_s;
  logic [15:0]         rd_data_r;
  logic                drive_hi_r;
  logic                drive_lo_r;
  logic [15:0]         rd_count_r;
  logic [15:0]         wr_count_r;
  logic                conflict_r;
  logic [15:0]         mem_r [DEPTH];

  logic                ce_n_s;
  logic                oe_n_s;
  logic                we_n_s;
  logic                ub_n_s;
  logic                lb_n_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                commit_s;
  logic                read_entry_s;
  logic                write_entry_s;
  logic                unused_addr_s;

  function automatic state_t decode_next(input logic ce_n, input logic oe_n, input logic we_n);
    state_t ns;
    if (ce_n) begin
      ns = IDLE;
    end else if (!we_n) begin
      ns = WRITE;
    end else if (!oe_n) begin
      ns = READ;
    end else begin
      ns = IDLE;
    end
    return ns;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ce_n_s = bus.sram_control[4];
  assign oe_n_s = bus.sram_control[3];
  assign we_n_s = bus.sram_control[2];
  assign ub_n_s = bus.sram_control[1];
  assign lb_n_s = bus.sram_control[0];
  // Upper address bits alias onto the implemented depth.
  assign addr_s        = bus.Direcciones[ADDR_W-1:0];
  assign unused_addr_s = ^bus.Direcciones[17:ADDR_W];

  assign next_s        = decode_next(ce_n_s, oe_n_s, we_n_s);
  assign read_entry_s  = (next_s == READ) && (state_r != READ);
  assign write_entry_s = (next_s == WRITE) && (state_r != WRITE);
  // A reset pending at the commit edge must suppress the write; memory itself has no reset.
  assign commit_s      = write_entry_s && !reset;

  // Storage array: one byte-laned commit per write entry.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      if (!ub_n_s) begin
        mem_r[addr_s][15:8] <= Datos[15:8];
      end
      if (!lb_n_s) begin
        mem_r[addr_s][7:0] <= Datos[7:0];
      end
    end
  end

  // Control FSM with registered read data, lane enables, counters and conflict flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rd_data_r  <= 16'h0000;
      drive_hi_r <= 1'b0;
      drive_lo_r <= 1'b0;
      rd_count_r <= 16'h0000;
      wr_count_r <= 16'h0000;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      drive_hi_r <= (next_s == READ) && !ub_n_s;
      drive_lo_r <= (next_s == READ) && !lb_n_s;
      if (next_s == READ) begin
        rd_data_r <= mem_r[addr_s];
      end
      if (read_entry_s) begin
        rd_count_r <= sat_inc(rd_count_r);
      end
      if (write_entry_s) begin
        wr_count_r <= sat_inc(wr_count_r);
      end
      if (!ce_n_s && !oe_n_s && !we_n_s) begin
        conflict_r <= 1'b1;
      end
    end
  end

  // Lane enables are cleared by reset, so the bus releases asynchronously.
  assign Datos[15:8] = drive_hi_r ? rd_data_r[15:8] : 8'hzz;
  assign Datos[7:0]  = drive_lo_r ? rd_data_r[7:0]  : 8'hzz;

  assign bus.rd_count = rd_count_r;
  assign bus.wr_count = wr_count_r;
  assign bus.conflict = conflict_r;

endmodule
